// File: rtl/mesh_ctrl_pkg.sv
// Shared definitions for the multi-mesh pipe controller.
//   mesh_state_t : controller FSM state encoding
//   idx_bits()   : slot-index width for a given slot count (never below 1)
package mesh_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_CLEAR_WAIT,
    ST_SEL,
    ST_MVP_GO,
    ST_MVP_WAIT,
    ST_DRAW_GO,
    ST_DRAW_WAIT,
    ST_NEXT,
    ST_FIN
  } mesh_state_t;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_mesh_controller.sv
// Frame sequencer for up to MESH_COUNT meshes through mvp_pipe and
// draw_triangle_pipe, with an optional screen clear at frame start.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   start                   begin a frame (level, sampled in IDLE)
//   continuous              chain frames back-to-back while high
//   mesh_enable[i]          slot enable
//   mesh_vert_count         per-slot vertex counts, slot i at [i*WIDTH +: WIDTH]
//   mesh_tri_count          per-slot triangle counts, same packing
//   mesh_strip[i]           1 = triangle strip, 0 = list
//   clear_start/clear_done  screen-clear handshake
//   mesh_sel                current slot index (drives pose/mesh-ROM mux)
//   mvp_pipe_*              mvp stage start/update pulses, count, done
//   draw_tri_pipe_*         draw stage start pulse, strip, count, done
//   busy                    high in every state except IDLE
//   done                    one-cycle pulse at frame end
//   frame_count             completed frames, wraps modulo 2^WIDTH
module multi_mesh_controller
  import mesh_ctrl_pkg::*;
#(
  parameter int MESH_COUNT = 4,
  parameter int WIDTH      = 32,
  parameter int IDX_W      = idx_bits(MESH_COUNT),
  parameter bit CLEAR_EN   = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        continuous,
  input  logic [MESH_COUNT-1:0]       mesh_enable,
  input  logic [MESH_COUNT*WIDTH-1:0] mesh_vert_count,
  input  logic [MESH_COUNT*WIDTH-1:0] mesh_tri_count,
  input  logic [MESH_COUNT-1:0]       mesh_strip,
  output logic                        clear_start,
  input  logic                        clear_done,
  output logic [IDX_W-1:0]            mesh_sel,
  output logic                        mvp_pipe_start,
  output logic                        mvp_pipe_update_mvp,
  output logic [WIDTH-1:0]            mvp_pipe_count,
  input  logic                        mvp_pipe_done,
  output logic                        draw_tri_pipe_start,
  output logic                        draw_tri_pipe_strip,
  output logic [WIDTH-1:0]            draw_tri_pipe_count,
  input  logic                        draw_tri_pipe_done,
  output logic                        busy,
  output logic                        done,
  output logic [WIDTH-1:0]            frame_count
);

  mesh_state_t state, state_next;

  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] vert_q;
  logic [WIDTH-1:0] tri_q;
  logic             strip_q;
  logic [WIDTH-1:0] frame_q;

  logic [WIDTH-1:0] vert_slot [MESH_COUNT];
  logic [WIDTH-1:0] tri_slot  [MESH_COUNT];

  for (genvar g = 0; g < MESH_COUNT; g++) begin : g_unpack
    assign vert_slot[g] = mesh_vert_count[g*WIDTH +: WIDTH];
    assign tri_slot[g]  = mesh_tri_count[g*WIDTH +: WIDTH];
  end

  logic             cur_en;
  logic             cur_strip;
  logic [WIDTH-1:0] cur_vert;
  logic [WIDTH-1:0] cur_tri;
  logic             last_slot;

  assign cur_en    = mesh_enable[idx];
  assign cur_strip = mesh_strip[idx];
  assign cur_vert  = vert_slot[idx];
  assign cur_tri   = tri_slot[idx];
  assign last_slot = (idx == IDX_W'(MESH_COUNT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      vert_q  <= '0;
      tri_q   <= '0;
      strip_q <= 1'b0;
      frame_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_SEL: begin
          vert_q  <= cur_vert;
          tri_q   <= cur_tri;
          strip_q <= cur_strip;
        end
        ST_NEXT: begin
          if (!last_slot) idx <= idx + IDX_W'(1);
        end
        // Index returns to slot 0 on every frame end, so both the IDLE
        // path and the continuous path start the next frame at slot 0.
        ST_FIN: begin
          frame_q <= frame_q + WIDTH'(1);
          idx     <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next          = state;
    clear_start         = 1'b0;
    mvp_pipe_start      = 1'b0;
    mvp_pipe_update_mvp = 1'b0;
    draw_tri_pipe_start = 1'b0;
    done                = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = CLEAR_EN ? ST_CLEAR : ST_SEL;
      end
      ST_CLEAR: begin
        clear_start = 1'b1;
        state_next  = ST_CLEAR_WAIT;
      end
      ST_CLEAR_WAIT: begin
        if (clear_done) state_next = ST_SEL;
      end
      // A slot with no vertices is skipped entirely, whatever its tri count.
      ST_SEL: begin
        state_next = (cur_en && (cur_vert != '0)) ? ST_MVP_GO : ST_NEXT;
      end
      ST_MVP_GO: begin
        mvp_pipe_start      = 1'b1;
        mvp_pipe_update_mvp = 1'b1;
        state_next          = ST_MVP_WAIT;
      end
      ST_MVP_WAIT: begin
        if (mvp_pipe_done) state_next = (tri_q != '0) ? ST_DRAW_GO : ST_NEXT;
      end
      ST_DRAW_GO: begin
        draw_tri_pipe_start = 1'b1;
        state_next          = ST_DRAW_WAIT;
      end
      ST_DRAW_WAIT: begin
        if (draw_tri_pipe_done) state_next = ST_NEXT;
      end
      ST_NEXT: begin
        state_next = last_slot ? ST_FIN : ST_SEL;
      end
      ST_FIN: begin
        done = 1'b1;
        if (continuous) state_next = CLEAR_EN ? ST_CLEAR : ST_SEL;
        else            state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mesh_sel            = idx;
  assign mvp_pipe_count      = vert_q;
  assign draw_tri_pipe_count = tri_q;
  assign draw_tri_pipe_strip = strip_q;
  assign frame_count         = frame_q;
  assign busy                = (state != ST_IDLE);

endmodule

// File: tb/tb_multi_mesh_controller.sv
module tb_multi_mesh_controller;

  localparam int MC  = 4;
  localparam int W   = 4;
  localparam int DLY = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          continuous;
  logic [MC-1:0] mesh_enable;
  logic [MC*W-1:0] mesh_vert_count;
  logic [MC*W-1:0] mesh_tri_count;
  logic [MC-1:0] mesh_strip;
  logic          clear_start;
  logic          clear_done;
  logic [1:0]    mesh_sel;
  logic          mvp_pipe_start;
  logic          mvp_pipe_update_mvp;
  logic [W-1:0]  mvp_pipe_count;
  logic          mvp_pipe_done;
  logic          draw_tri_pipe_start;
  logic          draw_tri_pipe_strip;
  logic [W-1:0]  draw_tri_pipe_count;
  logic          draw_tri_pipe_done;
  logic          busy;
  logic          done;
  logic [W-1:0]  frame_count;

  always #5 clock = ~clock;

  multi_mesh_controller #(
    .MESH_COUNT(MC),
    .WIDTH(W),
    .CLEAR_EN(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .continuous(continuous),
    .mesh_enable(mesh_enable),
    .mesh_vert_count(mesh_vert_count),
    .mesh_tri_count(mesh_tri_count),
    .mesh_strip(mesh_strip),
    .clear_start(clear_start),
    .clear_done(clear_done),
    .mesh_sel(mesh_sel),
    .mvp_pipe_start(mvp_pipe_start),
    .mvp_pipe_update_mvp(mvp_pipe_update_mvp),
    .mvp_pipe_count(mvp_pipe_count),
    .mvp_pipe_done(mvp_pipe_done),
    .draw_tri_pipe_start(draw_tri_pipe_start),
    .draw_tri_pipe_strip(draw_tri_pipe_strip),
    .draw_tri_pipe_count(draw_tri_pipe_count),
    .draw_tri_pipe_done(draw_tri_pipe_done),
    .busy(busy),
    .done(done),
    .frame_count(frame_count)
  );

  // Done responders: auto pulses DLY cycles after a start, plus manual drives.
  logic clr_auto, mvp_auto, draw_auto;
  logic mvp_manual, draw_manual;
  bit   mvp_auto_en  = 1'b1;
  bit   draw_auto_en = 1'b1;

  assign clear_done         = clr_auto;
  assign mvp_pipe_done      = mvp_auto | mvp_manual;
  assign draw_tri_pipe_done = draw_auto | draw_manual;

  initial begin
    clr_auto = 1'b0;
    forever begin
      @(negedge clock);
      if (clear_start) begin
        repeat (DLY - 1) @(negedge clock);
        clr_auto = 1'b1;
        @(negedge clock);
        clr_auto = 1'b0;
      end
    end
  end

  initial begin
    mvp_auto = 1'b0;
    forever begin
      @(negedge clock);
      if (mvp_pipe_start && mvp_auto_en) begin
        repeat (DLY - 1) @(negedge clock);
        mvp_auto = 1'b1;
        @(negedge clock);
        mvp_auto = 1'b0;
      end
    end
  end

  initial begin
    draw_auto = 1'b0;
    forever begin
      @(negedge clock);
      if (draw_tri_pipe_start && draw_auto_en) begin
        repeat (DLY - 1) @(negedge clock);
        draw_auto = 1'b1;
        @(negedge clock);
        draw_auto = 1'b0;
      end
    end
  end

  // Pulse recorder: counts events and captures slot data at each start pulse.
  int       n_clear = 0;
  int       n_done  = 0;
  int       mvp_hits  [MC];
  int       draw_hits [MC];
  logic [W-1:0] last_mvp_cnt  [MC];
  logic [W-1:0] last_draw_cnt [MC];
  logic         last_strip    [MC];
  logic         last_upd      [MC];

  always @(negedge clock) begin
    if (clear_start) n_clear++;
    if (done) n_done++;
    if (mvp_pipe_start) begin
      mvp_hits[mesh_sel]++;
      last_mvp_cnt[mesh_sel] = mvp_pipe_count;
      last_upd[mesh_sel]     = mvp_pipe_update_mvp;
    end
    if (draw_tri_pipe_start) begin
      draw_hits[mesh_sel]++;
      last_draw_cnt[mesh_sel] = draw_tri_pipe_count;
      last_strip[mesh_sel]    = draw_tri_pipe_strip;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (n_done < target && n < budget) begin
      tick();
      n++;
    end
    check("done_wait_bound", 32'(n_done >= target), 32'd1);
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_cfg(input logic [MC-1:0] en, input logic [MC*W-1:0] vc,
                           input logic [MC*W-1:0] tc, input logic [MC-1:0] st);
    mesh_enable     = en;
    mesh_vert_count = vc;
    mesh_tri_count  = tc;
    mesh_strip      = st;
  endtask

  function automatic int sum_hits(input int h [MC]);
    int s = 0;
    for (int i = 0; i < MC; i++) s += h[i];
    return s;
  endfunction

  typedef struct {
    string          name;
    logic [MC-1:0]  en;
    logic [MC*W-1:0] vcnt;
    logic [MC*W-1:0] tcnt;
    logic [MC-1:0]  strip;
    logic [MC-1:0]  exp_mvp;
    logic [MC-1:0]  exp_draw;
  } vec_t;

  vec_t vecs [4];

  logic [W-1:0] exp_fc;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_done, base_clear, base_mvp, base_draw, nfr;
    int mvp_base [MC];
    int draw_base [MC];

    vecs[0] = '{"all_on",   4'b1111, 16'h4444, 16'h2222, 4'b1111, 4'b1111, 4'b1111};
    vecs[1] = '{"en_0101",  4'b0101, 16'h4444, 16'h2222, 4'b0001, 4'b0101, 4'b0101};
    vecs[2] = '{"zero_cnt", 4'b1111, 16'h5034, 16'h1702, 4'b1010, 4'b1011, 4'b1001};
    vecs[3] = '{"all_off",  4'b0000, 16'h4444, 16'h2222, 4'b1111, 4'b0000, 4'b0000};

    reset       = 1'b1;
    start       = 1'b0;
    continuous  = 1'b0;
    mvp_manual  = 1'b0;
    draw_manual = 1'b0;
    apply_cfg(4'b1111, 16'h4444, 16'h2222, 4'b1111);
    exp_fc = '0;
    repeat (3) tick();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_pulses", 32'({clear_start, mvp_pipe_start, mvp_pipe_update_mvp,
                              draw_tri_pipe_start, done}), 32'd0);
    check("rst_regs", 32'({mesh_sel, mvp_pipe_count, draw_tri_pipe_count,
                            draw_tri_pipe_strip}), 32'd0);
    reset = 1'b0;
    tick();

    // Table-driven single frames
    for (int v = 0; v < 4; v++) begin
      apply_cfg(vecs[v].en, vecs[v].vcnt, vecs[v].tcnt, vecs[v].strip);
      mvp_base   = mvp_hits;
      draw_base  = draw_hits;
      base_done  = n_done;
      base_clear = n_clear;
      pulse_start();
      wait_done(base_done + 1, 1000);
      exp_fc = exp_fc + 4'd1;
      check({vecs[v].name, "_done_pulses"}, 32'(n_done - base_done), 32'd1);
      check({vecs[v].name, "_clear_pulses"}, 32'(n_clear - base_clear), 32'd1);
      check({vecs[v].name, "_frame_count"}, 32'(frame_count), 32'(exp_fc));
      check({vecs[v].name, "_idle"}, 32'(busy), 32'd0);
      for (int s = 0; s < MC; s++) begin
        check($sformatf("%s_mvp_hits_%0d", vecs[v].name, s),
              32'(mvp_hits[s] - mvp_base[s]), 32'(vecs[v].exp_mvp[s]));
        check($sformatf("%s_draw_hits_%0d", vecs[v].name, s),
              32'(draw_hits[s] - draw_base[s]), 32'(vecs[v].exp_draw[s]));
        if (vecs[v].exp_mvp[s]) begin
          check($sformatf("%s_mvp_cnt_%0d", vecs[v].name, s),
                32'(last_mvp_cnt[s]), 32'(vecs[v].vcnt[s*W +: W]));
          check($sformatf("%s_upd_%0d", vecs[v].name, s), 32'(last_upd[s]), 32'd1);
        end
        if (vecs[v].exp_draw[s]) begin
          check($sformatf("%s_draw_cnt_%0d", vecs[v].name, s),
                32'(last_draw_cnt[s]), 32'(vecs[v].tcnt[s*W +: W]));
          check($sformatf("%s_strip_%0d", vecs[v].name, s),
                32'(last_strip[s]), 32'(vecs[v].strip[s]));
        end
      end
    end

    // Continuous mode for three frames, with starts while busy ignored
    apply_cfg(4'b1111, 16'h4444, 16'h2222, 4'b1111);
    base_done = n_done;
    base_mvp  = sum_hits(mvp_hits);
    continuous = 1'b1;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      repeat (6) tick();
      pulse_start();
    end
    wait_done(base_done + 2, 1000);
    continuous = 1'b0;
    wait_done(base_done + 3, 1000);
    repeat (20) tick();
    exp_fc = exp_fc + 4'd3;
    check("cont_done_pulses", 32'(n_done - base_done), 32'd3);
    check("cont_frame_count", 32'(frame_count), 32'(exp_fc));
    check("cont_idle", 32'(busy), 32'd0);
    check("cont_mvp_total", 32'(sum_hits(mvp_hits) - base_mvp), 32'd12);

    // Stray done while idle, then done coincident with mvp start ignored
    apply_cfg(4'b0001, 16'h0004, 16'h0002, 4'b0000);
    mvp_auto_en = 1'b0;
    mvp_manual  = 1'b1;
    tick();
    mvp_manual  = 1'b0;
    repeat (2) tick();
    check("stray_mvp_done_idle", 32'(busy), 32'd0);
    base_done = n_done;
    base_draw = sum_hits(draw_hits);
    pulse_start();
    begin
      int n = 0;
      while (!mvp_pipe_start && n < 100) begin
        tick();
        n++;
      end
      check("mvp_start_seen", 32'(mvp_pipe_start), 32'd1);
    end
    mvp_manual = 1'b1;
    tick();
    mvp_manual = 1'b0;
    repeat (4) tick();
    check("same_cycle_done_busy", 32'(busy), 32'd1);
    check("same_cycle_done_no_draw", 32'(sum_hits(draw_hits) - base_draw), 32'd0);
    mvp_manual = 1'b1;
    tick();
    mvp_manual = 1'b0;
    wait_done(base_done + 1, 1000);
    exp_fc = exp_fc + 4'd1;
    mvp_auto_en = 1'b1;
    check("late_done_draw", 32'(sum_hits(draw_hits) - base_draw), 32'd1);
    check("late_done_frame_count", 32'(frame_count), 32'(exp_fc));

    // Reset in DRAW_WAIT, stray draw done afterwards, then a fresh frame
    apply_cfg(4'b1111, 16'h4444, 16'h2222, 4'b1111);
    draw_auto_en = 1'b0;
    base_draw = sum_hits(draw_hits);
    pulse_start();
    begin
      int n = 0;
      while (sum_hits(draw_hits) == base_draw && n < 200) begin
        tick();
        n++;
      end
      check("draw_start_seen", 32'(sum_hits(draw_hits) - base_draw), 32'd1);
    end
    repeat (2) tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_frame_count", 32'(frame_count), 32'd0);
    check("mid_rst_pulses", 32'({clear_start, mvp_pipe_start, mvp_pipe_update_mvp,
                                  draw_tri_pipe_start, done}), 32'd0);
    check("mid_rst_regs", 32'({mesh_sel, mvp_pipe_count, draw_tri_pipe_count,
                                draw_tri_pipe_strip}), 32'd0);
    reset = 1'b0;
    exp_fc = '0;
    tick();
    base_mvp  = sum_hits(mvp_hits);
    base_draw = sum_hits(draw_hits);
    base_done = n_done;
    draw_manual = 1'b1;
    tick();
    draw_manual = 1'b0;
    repeat (4) tick();
    check("stray_draw_busy", 32'(busy), 32'd0);
    check("stray_draw_no_starts", 32'(sum_hits(mvp_hits) + sum_hits(draw_hits) - base_mvp - base_draw), 32'd0);
    check("stray_draw_no_done", 32'(n_done - base_done), 32'd0);
    draw_auto_en = 1'b1;
    pulse_start();
    wait_done(base_done + 1, 1000);
    exp_fc = exp_fc + 4'd1;
    check("fresh_frame_count", 32'(frame_count), 32'(exp_fc));
    check("fresh_mvp_total", 32'(sum_hits(mvp_hits) - base_mvp), 32'd4);
    check("fresh_draw_total", 32'(sum_hits(draw_hits) - base_draw), 32'd4);

    // All slots disabled, run continuously until frame_count wraps
    apply_cfg(4'b0000, 16'h4444, 16'h2222, 4'b1111);
    nfr        = 16 - int'(exp_fc);
    base_done  = n_done;
    base_clear = n_clear;
    base_mvp   = sum_hits(mvp_hits);
    base_draw  = sum_hits(draw_hits);
    continuous = 1'b1;
    pulse_start();
    wait_done(base_done + nfr - 1, 2000);
    continuous = 1'b0;
    check("wrap_pre_count", 32'(frame_count), 32'hF);
    wait_done(base_done + nfr, 1000);
    repeat (2) tick();
    check("wrap_count_zero", 32'(frame_count), 32'd0);
    check("wrap_done_pulses", 32'(n_done - base_done), 32'(nfr));
    check("wrap_clear_pulses", 32'(n_clear - base_clear), 32'(nfr));
    check("wrap_no_pipe_starts", 32'(sum_hits(mvp_hits) + sum_hits(draw_hits) - base_mvp - base_draw), 32'd0);
    check("wrap_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
